// File: rtl/mpu707_sched_if.sv
// Bus between the 0.707 twiddle sequencer and the
// radix-8 stage datapath it controls.
interface mpu707_sched_if #(
  parameter int LOG2N = 3
);
  logic             EI;
  logic             START;
  logic             ED;
  logic             MPYJ;
  logic             BYP;
  logic [LOG2N-1:0] IDX;
  logic             OVAL;
  logic             BYP_D;
  logic             RDY;
  logic             DONE;
  logic             BUSY;

  modport master (
    output EI, START,
    input  ED, MPYJ, BYP, IDX,
    input  OVAL, BYP_D, RDY, DONE, BUSY
  );

  modport slave (
    input  EI, START,
    output ED, MPYJ, BYP, IDX,
    output OVAL, BYP_D, RDY, DONE, BUSY
  );
endinterface

// File: rtl/mpu707_sched.sv
// Sample sequencer for the shared 0.707 twiddle
// multiplier: strobes, -j select, aligned markers.
module mpu707_sched #(
  parameter int LOG2N   = 3,
  parameter int MPY_LAT = 4
) (
  input logic           CLK,
  input logic           RST,
  mpu707_sched_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_e;

  typedef struct packed {
    logic v;
    logic b;
    logic f;
    logic l;
  } tap_t;

  localparam logic [LOG2N-1:0] LAST = '1;

  state_e           st_q;
  logic             ph_q;
  logic [LOG2N-1:0] idx_q;
  logic [LOG2N-1:0] idx_d;
  logic [1:0]       k_d;
  logic             ed_q;
  logic             byp_q;
  logic             mpyj_q;
  logic             busy_q;
  tap_t             tap_d;
  tap_t             dl_q [MPY_LAT];
  logic             last_pend;

  assign idx_d = idx_q + 1'b1;
  assign k_d   = 2'(idx_d);

  always_comb begin
    tap_d   = '0;
    tap_d.v = ed_q;
    tap_d.b = byp_q;
    tap_d.f = ed_q && (idx_q == '0);
    tap_d.l = ed_q && (idx_q == LAST);
  end

  // Last sample still short of the output stage.
  always_comb begin
    last_pend = 1'b0;
    for (int i = 0; i < MPY_LAT - 1; i++)
      last_pend = last_pend | dl_q[i].l;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q   <= IDLE;
      ph_q   <= 1'b0;
      idx_q  <= '0;
      ed_q   <= 1'b0;
      byp_q  <= 1'b0;
      mpyj_q <= 1'b0;
      busy_q <= 1'b0;
      for (int i = 0; i < MPY_LAT; i++)
        dl_q[i] <= '0;
    end else if (bus.EI) begin
      ed_q   <= 1'b0;
      byp_q  <= 1'b0;
      mpyj_q <= 1'b0;
      if (bus.START) begin
        st_q   <= RUN;
        ph_q   <= 1'b0;
        idx_q  <= '0;
        ed_q   <= 1'b1;
        byp_q  <= 1'b1;
        busy_q <= 1'b1;
      end else begin
        unique case (st_q)
          RUN: begin
            if (!ph_q) begin
              ph_q <= 1'b1;
            end else if (idx_q == LAST) begin
              st_q  <= FLUSH;
              ph_q  <= 1'b0;
              idx_q <= '0;
            end else begin
              ph_q   <= 1'b0;
              idx_q  <= idx_d;
              ed_q   <= 1'b1;
              byp_q  <= ~k_d[0];
              mpyj_q <= k_d[1];
            end
          end
          FLUSH: begin
            if (!last_pend) begin
              st_q   <= IDLE;
              busy_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end
      dl_q[0] <= tap_d;
      for (int i = 1; i < MPY_LAT; i++)
        dl_q[i] <= dl_q[i-1];
    end
  end

  assign bus.ED    = ed_q;
  assign bus.MPYJ  = mpyj_q;
  assign bus.BYP   = byp_q;
  assign bus.IDX   = idx_q;
  assign bus.BUSY  = busy_q;
  assign bus.OVAL  = dl_q[MPY_LAT-1].v;
  assign bus.BYP_D = dl_q[MPY_LAT-1].b;
  assign bus.RDY   = dl_q[MPY_LAT-1].f;
  assign bus.DONE  = dl_q[MPY_LAT-1].l;
endmodule

// File: tb/tb_mpu707_sched.sv
// Bench for mpu707_sched: two parameter sets driven in
// lockstep, checked against a per-cycle schedule model.
module tb_mpu707_sched;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ei = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  mpu707_sched_if #(.LOG2N(3)) ifa ();
  mpu707_sched_if #(.LOG2N(4)) ifb ();

  assign ifa.EI = ei;
  assign ifa.START = start;
  assign ifb.EI = ei;
  assign ifb.START = start;

  mpu707_sched #(.LOG2N(3), .MPY_LAT(4)) u_a (
    .CLK(clk), .RST(rst), .bus(ifa)
  );
  mpu707_sched #(.LOG2N(4), .MPY_LAT(6)) u_b (
    .CLK(clk), .RST(rst), .bus(ifb)
  );

  logic [7:0] act [2];
  logic [4:0] aidx [2];
  assign act[0] = {ifa.ED, ifa.MPYJ, ifa.BYP, ifa.OVAL,
                   ifa.BYP_D, ifa.RDY, ifa.DONE, ifa.BUSY};
  assign act[1] = {ifb.ED, ifb.MPYJ, ifb.BYP, ifb.OVAL,
                   ifb.BYP_D, ifb.RDY, ifb.DONE, ifb.BUSY};
  assign aidx[0] = 5'(ifa.IDX);
  assign aidx[1] = 5'(ifb.IDX);

  int lg [2] = '{3, 4};
  int lat [2] = '{4, 6};

  // Model: what each signal must show at enabled cycle n.
  bit s_ed [2][MAXC];
  bit s_byp [2][MAXC];
  bit s_mj [2][MAXC];
  bit s_f [2][MAXC];
  bit s_l [2][MAXC];
  int s_idx [2][MAXC];
  int n = 0;
  int last_rst = 0;
  int busy_end [2] = '{-1, -1};
  bit armed = 0;

  int asserts = 0;
  int fails = 0;

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    asserts++;
    if (a !== e) begin
      fails++;
      if (fails <= 40)
        $display("FAIL %s n=%0d: got %0d want %0d",
                 nm, n, a, e);
    end
  endtask

  task automatic clr(int i, int lo, int hi);
    for (int m = lo; m <= hi; m++) begin
      if (m >= 0 && m < MAXC) begin
        s_ed[i][m] = 0;
        s_byp[i][m] = 0;
        s_mj[i][m] = 0;
        s_f[i][m] = 0;
        s_l[i][m] = 0;
        s_idx[i][m] = 0;
      end
    end
  endtask

  task automatic do_start(int t);
    for (int i = 0; i < 2; i++) begin
      int nn;
      nn = 1 << lg[i];
      clr(i, t + 1, t + 2 * nn + 2);
      for (int k = 0; k < nn; k++) begin
        int c;
        c = t + 1 + 2 * k;
        if (c < MAXC) begin
          s_ed[i][c] = 1;
          s_idx[i][c] = k;
          s_byp[i][c] = ((k % 4) % 2) == 0;
          s_mj[i][c] = (k % 4) >= 2;
          s_f[i][c] = (k == 0);
          s_l[i][c] = (k == nn - 1);
        end
      end
      busy_end[i] = t + 2 * nn - 1 + lat[i];
    end
  endtask

  initial forever begin
    @(posedge clk);
    if (rst) begin
      n++;
      last_rst = n;
      for (int i = 0; i < 2; i++) begin
        clr(i, n, n + 40);
        busy_end[i] = -1;
      end
      armed = 1;
    end else if (ei) begin
      if (start) do_start(n);
      n++;
    end
  end

  string nm [8] = '{"ED", "MPYJ", "BYP", "OVAL",
                    "BYP_D", "RDY", "DONE", "BUSY"};

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      int m;
      bit [7:0] e;
      m = n - lat[i];
      e = '0;
      e[7] = s_ed[i][n];
      e[6] = s_mj[i][n];
      e[5] = s_byp[i][n];
      if (m >= 0 && m >= last_rst) begin
        e[4] = s_ed[i][m];
        e[3] = s_byp[i][m];
        e[2] = s_f[i][m];
        e[1] = s_l[i][m];
      end
      e[0] = (n <= busy_end[i]);
      for (int b = 0; b < 8; b++)
        chk($sformatf("%s[%0d]", nm[7-b], i),
            32'(act[i][b]), 32'(e[b]));
      if (e[7])
        chk($sformatf("IDX[%0d]", i),
            32'(aidx[i]), s_idx[i][n]);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (armed && n < MAXC) compare();
  end

  task automatic cyc(bit r, bit e, bit s);
    @(negedge clk);
    rst = r;
    ei = e;
    start = s;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_wait();
    repeat (45) cyc(0, 1, 0);
  endtask

  initial begin
    int t;
    int rel;
    bit [31:0] edm;
    bit [7:0] bp;
    bit [7:0] mj;
    int ra, da, bl, rb, db, eb;
    int ovo, dc, ed7, ix7, r2, e2, ovc;
    logic [7:0] post;

    repeat (3) cyc(1, 0, 0);
    cyc(0, 1, 0);

    // Single block, both parameter sets.
    cyc(0, 1, 1);
    t = n - 1;
    edm = '0; bp = '0; mj = '0;
    ra = -1; da = -1; bl = -1;
    rb = -1; db = -1; eb = 0;
    for (int k = 0; k < 45; k++) begin
      rel = n - t;
      if (ifa.ED) begin
        if (rel < 32) edm[rel] = 1'b1;
        bp = {bp[6:0], ifa.BYP};
        mj = {mj[6:0], ifa.MPYJ};
      end
      if (ifa.RDY && ra < 0) ra = rel;
      if (ifa.DONE && da < 0) da = rel;
      if (!ifa.BUSY && bl < 0) bl = rel;
      if (ifb.RDY && rb < 0) rb = rel;
      if (ifb.DONE && db < 0) db = rel;
      if (ifb.ED) eb++;
      cyc(0, 1, 0);
    end
    chk("s1_ed_cycles", edm, 32'h0000AAAA);
    chk("s1_byp_pat", 32'(bp), 32'hAA);
    chk("s1_mpyj_pat", 32'(mj), 32'h33);
    chk("s1_rdy", ra, 5);
    chk("s1_done", da, 19);
    chk("s1_busy_low", bl, 20);
    chk("s1b_rdy", rb, 7);
    chk("s1b_done", db, 37);
    chk("s1b_ed_count", eb, 16);

    // EI toggling: timing counted in enabled cycles.
    cyc(0, 1, 1);
    t = n - 1;
    da = -1;
    for (int k = 0; k < 60; k++) begin
      rel = n - t;
      if (ifa.DONE && da < 0) da = rel;
      cyc(0, k[0], 0);
    end
    chk("s2_done", da, 19);
    idle_wait();

    // Restart mid-block at cycle 6.
    cyc(0, 1, 1);
    t = n - 1;
    ovo = 0; dc = 0; da = -1; ed7 = 0; ix7 = -1;
    for (int k = 0; k < 40; k++) begin
      rel = n - t;
      if (ifa.OVAL && rel < 11) ovo++;
      if (ifa.DONE) begin dc++; da = rel; end
      if (rel == 7) begin
        ed7 = 32'(ifa.ED);
        ix7 = 32'(ifa.IDX);
      end
      cyc(0, 1, rel == 6);
    end
    chk("s3_trunc_oval", ovo, 3);
    chk("s3_done_count", dc, 1);
    chk("s3_done", da, 25);
    chk("s3_ed7", ed7, 1);
    chk("s3_idx7", ix7, 0);
    idle_wait();

    // Back-to-back blocks, second START at 16.
    cyc(0, 1, 1);
    t = n - 1;
    dc = 0; da = -1; r2 = -1; e2 = -1; ovc = 0;
    for (int k = 0; k < 45; k++) begin
      rel = n - t;
      if (ifa.DONE) begin
        dc++;
        if (da < 0) da = rel;
      end
      if (ifa.RDY && rel > 5 && r2 < 0) r2 = rel;
      if (ifa.ED && rel > 15 && e2 < 0) e2 = rel;
      if (ifa.OVAL) ovc++;
      cyc(0, 1, rel == 16);
    end
    chk("s4_done1", da, 19);
    chk("s4_rdy2", r2, 21);
    chk("s4_ed2", e2, 17);
    chk("s4_oval_count", ovc, 16);
    chk("s4_done_count", dc, 2);
    idle_wait();

    // Reset at cycle 9 during RUN.
    cyc(0, 1, 1);
    ovc = 0;
    post = '1;
    for (int k = 0; k < 8; k++) cyc(0, 1, 0);
    cyc(1, 1, 0);
    post = act[0];
    for (int k = 0; k < 25; k++) begin
      ovc += int'(ifa.OVAL) + int'(ifa.DONE)
           + int'(ifa.BUSY) + int'(ifa.ED);
      cyc(0, 1, 0);
    end
    chk("s5_after_rst", 32'(post), 0);
    chk("s5_quiet", ovc, 0);

    // START coincident with RST is ignored.
    cyc(1, 1, 1);
    cyc(0, 1, 0);
    chk("s6_busy", 32'(ifa.BUSY), 0);
    chk("s6_ed", 32'(ifa.ED), 0);

    // Randomized traffic against the model.
    for (int k = 0; k < 2500; k++) begin
      bit r, e, s;
      r = ($urandom_range(0, 199) == 0);
      e = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 24) == 0)
          && !s_ed[0][n] && !s_ed[1][n];
      if (n > MAXC - 80) break;
      cyc(r, e, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end
endmodule
